// File: rtl/json_feedback_rx.sv
// Parses rover reply lines {"T":<int>,"L":<dec>,"R":<dec>}\n from a uart_rx byte stream into binary fields.
// Optional inter-byte timeout is built only when JSON_RX_TIMEOUT_EN is defined.
module json_feedback_rx #(
  parameter int MAX_T_DIGITS = 4,
  parameter int T_WIDTH      = 14
`ifdef JSON_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 50_000_000/100
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic [T_WIDTH-1:0] cmd_type,
  output logic [11:0]        left_speed,
  output logic [11:0]        right_speed,
  output logic               frame_valid,
  output logic               frame_error,
  output logic               busy
);

  typedef enum logic [3:0] {
    IDLE, HDR_T, NUM_T, HDR_L, NUM_L, HDR_R, NUM_R, CLOSE, EOL
  } state_t;

  // Position inside an L/R field: what the next byte may legally be.
  typedef enum logic [2:0] {
    F_SIGN, F_INT, F_DOT, F_FRAC1, F_FRAC2, F_END
  } fphase_t;

  localparam int TCW = $clog2(MAX_T_DIGITS + 1);

  state_t             state;
  fphase_t            f_phase;
  logic [2:0]         idx;
  logic [T_WIDTH-1:0] t_acc;
  logic [TCW-1:0]     t_cnt;
  logic [9:0]         f_mag;
  logic               f_neg;
  logic [11:0]        l_val;
  logic [11:0]        r_val;

  logic               is_digit;
  logic [3:0]         digit;
  logic [2:0]         hdr_pos;
  logic [7:0]         hdr_char;
  logic [7:0]         f_term;
  logic               byte_ok;
  logic               timeout_hit;
  logic [T_WIDTH-1:0] t_mul;
  logic [11:0]        f_val;

  assign is_digit = (byte_in >= "0") && (byte_in <= "9");
  assign digit    = byte_in[3:0];
  assign t_mul    = t_acc * T_WIDTH'(10) + T_WIDTH'(digit);
  assign f_val    = f_neg ? (12'd0 - {2'b00, f_mag}) : {2'b00, f_mag};
  assign f_term   = (state == NUM_L) ? 8'(",") : 8'("}");
  assign busy     = (state != IDLE);

  // All three headers share the pattern ,"x": ; HDR_T skips the leading comma.
  assign hdr_pos = (state == HDR_T) ? idx + 3'd1 : idx;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    hdr_char = 8'(",");
    case (hdr_pos)
      3'd1, 3'd3: hdr_char = 8'("\"");
      3'd2:       hdr_char = (state == HDR_T) ? 8'("T") :
                             (state == HDR_L) ? 8'("L") : 8'("R");
      3'd4:       hdr_char = 8'(":");
      default:    hdr_char = 8'(",");
    endcase
  end

  always_comb begin
    byte_ok = 1'b0;
    case (state)
      IDLE:                byte_ok = 1'b1;
      HDR_T, HDR_L, HDR_R: byte_ok = (byte_in == hdr_char);
      NUM_T:               byte_ok = (is_digit && (t_cnt < TCW'(MAX_T_DIGITS))) ||
                                     ((byte_in == ",") && (t_cnt != '0));
      NUM_L, NUM_R: begin
        case (f_phase)
          F_SIGN:  byte_ok = is_digit || (byte_in == "-");
          F_INT:   byte_ok = is_digit;
          F_DOT:   byte_ok = (byte_in == ".");
          F_FRAC1: byte_ok = is_digit;
          F_FRAC2: byte_ok = is_digit || (byte_in == f_term);
          default: byte_ok = (byte_in == f_term);
        endcase
      end
      EOL:                 byte_ok = (byte_in == "\r") || (byte_in == "\n");
      default:             byte_ok = 1'b0;
    endcase
  end

`ifdef JSON_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  logic [CW-1:0] idle_cnt;

  assign timeout_hit = busy && !byte_valid && (idle_cnt == CW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  idle_cnt <= '0;
    else if (byte_valid || !busy || timeout_hit) idle_cnt <= '0;
    else                                       idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      f_phase     <= F_SIGN;
      idx         <= '0;
      t_acc       <= '0;
      t_cnt       <= '0;
      f_mag       <= '0;
      f_neg       <= 1'b0;
      l_val       <= '0;
      r_val       <= '0;
      cmd_type    <= '0;
      left_speed  <= '0;
      right_speed <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (timeout_hit) begin
        frame_error <= 1'b1;
        state       <= IDLE;
      end else if (byte_valid) begin
        if ((state != IDLE) && !byte_ok) begin
          frame_error <= 1'b1;
          // A stray '{' is treated as the start of the next frame.
          if (byte_in == "{") begin
            state <= HDR_T;
            idx   <= '0;
            t_acc <= '0;
            t_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end else begin
          case (state)
            IDLE: if (byte_in == "{") begin
              state <= HDR_T;
              idx   <= '0;
              t_acc <= '0;
              t_cnt <= '0;
            end
            HDR_T, HDR_L, HDR_R: begin
              if (hdr_pos == 3'd4) begin
                state   <= (state == HDR_T) ? NUM_T : (state == HDR_L) ? NUM_L : NUM_R;
                f_phase <= F_SIGN;
                f_mag   <= '0;
                f_neg   <= 1'b0;
              end else begin
                idx <= idx + 3'd1;
              end
            end
            NUM_T: begin
              if (is_digit) begin
                t_acc <= t_mul;
                t_cnt <= t_cnt + 1'b1;
              end else begin
                state <= HDR_L;
                idx   <= 3'd1;
              end
            end
            NUM_L, NUM_R: begin
              if (byte_in == "-") begin
                f_neg   <= 1'b1;
                f_phase <= F_INT;
              end else if (byte_in == ".") begin
                f_phase <= F_FRAC1;
              end else if (is_digit) begin
                case (f_phase)
                  F_SIGN, F_INT: begin
                    f_mag   <= {6'd0, digit} * 10'd100;
                    f_phase <= F_DOT;
                  end
                  F_FRAC1: begin
                    f_mag   <= f_mag + {6'd0, digit} * 10'd10;
                    f_phase <= F_FRAC2;
                  end
                  default: begin
                    f_mag   <= f_mag + {6'd0, digit};
                    f_phase <= F_END;
                  end
                endcase
              end else if (state == NUM_L) begin
                l_val <= f_val;
                state <= HDR_R;
                idx   <= 3'd1;
              end else begin
                r_val <= f_val;
                state <= EOL;
              end
            end
            EOL: if (byte_in == "\n") begin
              cmd_type    <= t_acc;
              left_speed  <= l_val;
              right_speed <= r_val;
              frame_valid <= 1'b1;
              state       <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_json_feedback_rx.sv
// Directed bench for json_feedback_rx: good frames, malformed frames, resync, mid-frame reset and timeout.
module tb_json_feedback_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic [13:0] cmd_type;
  logic [11:0] left_speed;
  logic [11:0] right_speed;
  logic        frame_valid;
  logic        frame_error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int f0, e0;

  always #5 clk = ~clk;

  json_feedback_rx #(
    .MAX_T_DIGITS(4),
    .T_WIDTH(14)
`ifdef JSON_RX_TIMEOUT_EN
    , .TIMEOUT_CLKS(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .cmd_type(cmd_type), .left_speed(left_speed), .right_speed(right_speed),
    .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
  );

  // Pulse counters; sampled at posedge so they see the previous cycle's strobes.
  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
  end

  // Drives the string back-to-back, one byte per cycle; returns on the negedge after the last byte.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      byte_in    = s[i];
      byte_valid = 1'b1;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'd0;
  endtask

  task automatic expect_frame(input string name, input logic [13:0] t,
                              input logic [11:0] l, input logic [11:0] r);
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL %s_fv: got %b expected 1", name, frame_valid); end
    vectors++; if (cmd_type !== t) begin miscompares++; $display("FAIL %s_cmd: got %0d expected %0d", name, cmd_type, t); end
    vectors++; if (left_speed !== l) begin miscompares++; $display("FAIL %s_left: got %h expected %h", name, left_speed, l); end
    vectors++; if (right_speed !== r) begin miscompares++; $display("FAIL %s_right: got %h expected %h", name, right_speed, r); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy: got %b expected 0", name, busy); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if (cmd_type !== 14'd0) begin miscompares++; $display("FAIL rst_cmd: got %0d expected 0", cmd_type); end
    vectors++; if (left_speed !== 12'd0 || right_speed !== 12'd0) begin miscompares++; $display("FAIL rst_speed: got %h/%h expected 0/0", left_speed, right_speed); end
    vectors++; if ({frame_valid, frame_error, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b expected 000", {frame_valid, frame_error, busy}); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    f0 = fv_cnt; e0 = fe_cnt;
    send_str("{\"T\":1001,\"L\":0.3,\"R\":0.55}");
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_mid: got %b expected 1", busy); end
    vectors++; if (cmd_type !== 14'd0) begin miscompares++; $display("FAIL basic_early: got %0d expected 0", cmd_type); end
    send_str("\n");
    expect_frame("basic", 14'd1001, 12'd30, 12'd55);
    @(negedge clk);
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_fv_width: got %b expected 0", frame_valid); end
    @(negedge clk);
    vectors++; if (fv_cnt - f0 !== 1 || fe_cnt - e0 !== 0) begin miscompares++; $display("FAIL basic_counts: got fv=%0d fe=%0d expected 1/0", fv_cnt - f0, fe_cnt - e0); end
  endtask

  task automatic test_negative;
    send_str("{\"T\":1,\"L\":-0.25,\"R\":-1.0}\r");
    vectors++; if (frame_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL neg_cr: got fv=%b busy=%b expected 0/1", frame_valid, busy); end
    send_str("\n");
    expect_frame("neg", 14'd1, 12'hFE7, 12'hF9C);
  endtask

  task automatic test_t_overflow;
    send_str("{\"T\":1234");
    vectors++; if (frame_error !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL tovf_pre: got fe=%b busy=%b expected 0/1", frame_error, busy); end
    send_str("5");
    vectors++; if (frame_error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL tovf_err: got fe=%b busy=%b expected 1/0", frame_error, busy); end
    vectors++; if (cmd_type !== 14'd1 || left_speed !== 12'hFE7) begin miscompares++; $display("FAIL tovf_hold: got %0d/%h expected 1/fe7", cmd_type, left_speed); end
    @(negedge clk);
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL tovf_fe_width: got %b expected 0", frame_error); end
    send_str("{\"T\":9999,\"L\":9.99,\"R\":-9.99}\n");
    expect_frame("tmax", 14'd9999, 12'd999, 12'hC19);
  endtask

  task automatic test_resync;
    e0 = fe_cnt;
    send_str("{\"T\":1,\"L\":0.3");
    send_str("{");
    vectors++; if (frame_error !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL resync_err: got fe=%b busy=%b expected 1/1", frame_error, busy); end
    send_str("\"T\":2,\"L\":0.1,\"R\":0.2}\n");
    expect_frame("resync", 14'd2, 12'd10, 12'd20);
    @(negedge clk);
    vectors++; if (fe_cnt - e0 !== 1) begin miscompares++; $display("FAIL resync_fe_count: got %0d expected 1", fe_cnt - e0); end
  endtask

  task automatic test_errors;
    string bad [5];
    bad = '{"{\"T\":,", "{\"T\":1,\"L\":0.123", "{\"T\":1,\"L\":0-",
            "{\"T\":1,\"L\":0.5,\"R\":.", "{\"T\":1]"};
    for (int i = 0; i < 5; i++) begin
      send_str(bad[i]);
      vectors++; if (frame_error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL err_%0d: got fe=%b busy=%b expected 1/0", i, frame_error, busy); end
    end
    vectors++; if (cmd_type !== 14'd2 || left_speed !== 12'd10 || right_speed !== 12'd20) begin miscompares++; $display("FAIL err_hold: got %0d/%0d/%0d expected 2/10/20", cmd_type, left_speed, right_speed); end
    send_str("{\"T\":0,\"L\":-0.0,\"R\":-0.00}\n");
    expect_frame("negzero", 14'd0, 12'd0, 12'd0);
  endtask

  task automatic test_mid_reset;
    send_str("{\"T\":5,\"L\":1.5,\"R\":2.25}\n");
    expect_frame("pre_rst", 14'd5, 12'd150, 12'd225);
    send_str("{\"T\":3,\"L\":0.1,\"R\":0.");
    f0 = fv_cnt; e0 = fe_cnt;
    rst = 1'b0;
    #1;
    vectors++; if (cmd_type !== 14'd0 || left_speed !== 12'd0 || right_speed !== 12'd0) begin miscompares++; $display("FAIL midrst_out: got %0d/%0d/%0d expected 0/0/0", cmd_type, left_speed, right_speed); end
    vectors++; if ({frame_valid, frame_error, busy} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got %b expected 000", {frame_valid, frame_error, busy}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (fv_cnt !== f0 || fe_cnt !== e0) begin miscompares++; $display("FAIL midrst_strobes: got fv=%0d fe=%0d expected 0/0", fv_cnt - f0, fe_cnt - e0); end
    send_str("{\"T\":7,\"L\":-5.5,\"R\":0.07}\n");
    expect_frame("post_rst", 14'd7, 12'hDDA, 12'd7);
  endtask

  task automatic test_timeout;
    e0 = fe_cnt;
    send_str("{\"T\":1");
`ifdef JSON_RX_TIMEOUT_EN
    repeat (99) @(negedge clk);
    vectors++; if (frame_error !== 1'b0 || fe_cnt !== e0 || busy !== 1'b1) begin miscompares++; $display("FAIL tmo_early: got fe=%b cnt=%0d busy=%b expected 0/0/1", frame_error, fe_cnt - e0, busy); end
    @(negedge clk);
    vectors++; if (frame_error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL tmo_fire: got fe=%b busy=%b expected 1/0", frame_error, busy); end
`else
    repeat (150) @(negedge clk);
    vectors++; if (busy !== 1'b1 || fe_cnt !== e0) begin miscompares++; $display("FAIL tmo_stall: got busy=%b fe=%0d expected 1/0", busy, fe_cnt - e0); end
    send_str("}");
    vectors++; if (frame_error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL tmo_cleanup: got fe=%b busy=%b expected 1/0", frame_error, busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_t_overflow();
    test_resync();
    test_errors();
    test_mid_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/json_feedback_rx.md
Name: json_feedback_rx

Overview:
- Receive-side counterpart of the rover JSON command transmitters.
- Consumes the byte stream from uart_rx (one strobe per received byte) carrying rover replies of the form {"T":<int>,"L":<dec>,"R":<dec>}\n.
- Parses each line into binary fields and publishes them with a one-cycle frame_valid strobe.
- Feeds the motor-control FSM and LCD status logic.

Parameters:
- MAX_T_DIGITS, 4, maximum decimal digits accepted in the T field.
- T_WIDTH, 14, width of the binary T output (must hold 10^MAX_T_DIGITS-1).
- TIMEOUT_CLKS, 50_000_000/100, inter-byte timeout in clocks (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte, valid only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe from uart_rx.
- cmd_type  out  T_WIDTH  parsed T value (unsigned binary).
- left_speed  out  12  parsed L, signed two's complement, units of 0.01.
- right_speed  out  12  parsed R, same format as left_speed.
- frame_valid  out  1  one-cycle pulse: new fields are valid.
- frame_error  out  1  one-cycle pulse: malformed frame discarded.
- busy  out  1  high from accepted '{' until frame end or error.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM in IDLE, accumulators cleared.
- Input acceptance:
  - Bytes are only examined when byte_valid=1.
  - No backpressure: a byte is accepted every strobe, including back-to-back strobes on consecutive cycles.
- States: IDLE, HDR_T, NUM_T, HDR_L, NUM_L, HDR_R, NUM_R, CLOSE, EOL.
- IDLE: discard everything except '{', which moves to HDR_T.
- HDR_x: match a literal sequence via a match index.
  - HDR_T matches "T":
  - HDR_L matches ,"L":
  - HDR_R matches ,"R":
  - On full match go to the matching NUM_x state.
- NUM_T: accepts 1..MAX_T_DIGITS digits, accumulating acc = acc*10 + digit.
  - The terminating ',' is consumed as the first literal of HDR_L.
- NUM_L / NUM_R grammar: optional '-', exactly one integer digit, '.', then one or two fractional digits.
  - Value = int*100 + frac, in hundredths.
  - A single fractional digit is scaled by 10, so 0.3 gives 30.
  - Negate if '-' was seen. -0.0 yields 0.
  - Range is -999..999.
  - The terminator is ',' (NUM_L, consumed as the first literal of HDR_R) or '}' (NUM_R, moves to EOL).
- EOL: '\r' is ignored; '\n' completes the frame.
- Frame completion:
  - On the cycle after '\n' is accepted, cmd_type, left_speed and right_speed update together and frame_valid=1 for exactly one cycle.
  - Outputs then hold until the next good frame.
  - Latency: '\n' strobe at cycle n gives frame_valid at n+1.
- Error (frame_error for one cycle; outputs unchanged; partial values are never published). Triggered by any of:
  - an unexpected byte in any non-IDLE state;
  - a missing digit;
  - more than MAX_T_DIGITS digits in T;
  - a third fractional digit;
  - '-' appearing anywhere except first in an L/R field.
- Error recovery:
  - Normally the FSM returns to IDLE.
  - If the offending byte is '{', the FSM goes directly to HDR_T (resync, no byte lost).
  - frame_error and a new '{' acceptance may therefore occur on the same cycle.
- busy: 1 in every state except IDLE.
- Reset mid-frame: abandon the frame immediately, no strobe, outputs return to 0.

Optional Feature:
- Macro: JSON_RX_TIMEOUT_EN.
- When defined:
  - An idle counter increments each clock while busy=1 and clears on every byte_valid.
  - When it reaches TIMEOUT_CLKS, pulse frame_error and return to IDLE.
- When undefined:
  - No counter is built.
  - A stalled frame waits indefinitely until the next byte arrives.

Test Plan:
- Send {"T":1001,"L":0.3,"R":0.55}\n back-to-back → one frame_valid one cycle after '\n'; cmd_type=1001, left_speed=30, right_speed=55; no frame_error.
- Send {"T":1,"L":-0.25,"R":-1.0}\r\n → cmd_type=1, left_speed=-25 (12'hFE7), right_speed=-100; '\r' ignored.
- Send {"T":12345,... with MAX_T_DIGITS=4 → frame_error on the '5' byte, busy drops, outputs keep previous values. Follow with a valid frame → it parses correctly.
- Send {"T":1,"L":0.3{"T":2,"L":0.1,"R":0.2}\n → frame_error on the second '{', then frame_valid with cmd_type=2, left_speed=10, right_speed=20.
- Assert rst=0 midway through the R field → outputs 0 immediately, no strobes. After release, a full valid frame parses normally.
- With JSON_RX_TIMEOUT_EN defined and TIMEOUT_CLKS=100, stop after {"T":1 → frame_error exactly 100 clocks after the last strobe, busy=0. Without the macro, busy stays 1.
